// File: rtl/cb_cfg_pkg.sv
// Shared constants, sizing helper and counter-state type for the
// connection block configuration loader.
package cb_cfg_pkg;

  localparam int CB_W       = 16;
  localparam int CB_DATAIN  = 3;
  localparam int CB_DATAOUT = 2;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } cfg_state_t;

  function automatic int cfg_nbits(input int w, input int din, input int dout);
    return w * (din + dout);
  endfunction

endpackage

// File: rtl/connection_block_cfg_loader_shadow.sv
// Shadow shift register for the configuration loader; new bits enter at the
// top and the oldest bit leaves through dout (bit 0) towards the next loader.
module cfg_shadow_shift #(
  parameter int NBITS = 80
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  output logic [NBITS-1:0] sh,
  output logic             dout
);

  logic [NBITS-1:0] sh_next;

  generate
    for (genvar gi = 0; gi < NBITS; gi++) begin : g_bit
      if (gi == NBITS - 1) begin : g_top
        assign sh_next[gi] = en ? din : sh[gi];
      end else begin : g_body
        assign sh_next[gi] = en ? sh[gi+1] : sh[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh <= '0;
    end else begin
      sh <= sh_next;
    end
  end

  assign dout = sh[0];

endmodule

// File: rtl/connection_block_cfg_loader.sv
// Serial config loader for one connection block: shift into a shadow register,
// commit atomically to c. Build macro CFG_PARITY_EN adds an even-parity gate.
module connection_block_cfg_loader
  import cb_cfg_pkg::*;
#(
  parameter int  W       = CB_W,
  parameter int  DATAIN  = CB_DATAIN,
  parameter int  DATAOUT = CB_DATAOUT,
  localparam int NBITS   = cfg_nbits(W, DATAIN, DATAOUT),
  localparam int CW      = $clog2(NBITS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_en,
  input  logic             cfg_in,
  output logic             cfg_out,
  input  logic             cfg_load,
  input  logic             cfg_par,
  output logic [NBITS-1:0] c,
  output logic             cfg_done,
  output logic             cfg_err
);

  localparam logic [CW-1:0] CNT_FULL = CW'(NBITS);

  logic [NBITS-1:0] sh;
  logic [NBITS-1:0] c_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             done_next, err_next;
  logic             par_ok, commit_ok;
  cfg_state_t       state;

  cfg_shadow_shift #(.NBITS(NBITS)) u_shadow (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (cfg_en),
    .din  (cfg_in),
    .sh   (sh),
    .dout (cfg_out)
  );

`ifdef CFG_PARITY_EN
  assign par_ok = ((^sh) == cfg_par);
`else
  logic unused_par;
  assign unused_par = cfg_par;
  assign par_ok     = 1'b1;
`endif

  always_comb begin
    state = PARTIAL;
    if (cnt_reg == '0) state = EMPTY;
    else if (cnt_reg == CNT_FULL) state = FULL;
  end

  assign commit_ok = cfg_load && (state == FULL) && par_ok;

  // A shift coinciding with a successful commit is the first bit of the next frame.
  always_comb begin
    cnt_next  = cnt_reg;
    c_next    = c;
    done_next = commit_ok;
    err_next  = cfg_err;
    if (commit_ok) begin
      cnt_next = cfg_en ? CW'(1) : '0;
      c_next   = sh;
      err_next = 1'b0;
    end else begin
      if (cfg_load) err_next = 1'b1;
      if (cfg_en && (state != FULL)) cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      c        <= '0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      c        <= c_next;
      cfg_done <= done_next;
      cfg_err  <= err_next;
    end
  end

endmodule

// File: tb/tb_connection_block_cfg_loader.sv
// Self-checking bench for connection_block_cfg_loader: table of load/commit
// vectors plus hand-written sequences for reset, chaining and simultaneous events.
module tb_connection_block_cfg_loader;

  localparam int NBITS = 80;

  logic             clk = 1'b0;
  logic             rst_n, cfg_en, cfg_in, cfg_load, cfg_par;
  logic             cfg_out, cfg_done, cfg_err;
  logic [NBITS-1:0] c;

  int               checks = 0;
  int               errors = 0;
  bit               q[$];
  logic [NBITS-1:0] exp_c;

  typedef struct {
    int nshift;
    int pat;
    bit exp_ok;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  connection_block_cfg_loader dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg_en  (cfg_en),
    .cfg_in  (cfg_in),
    .cfg_out (cfg_out),
    .cfg_load(cfg_load),
    .cfg_par (cfg_par),
    .c       (c),
    .cfg_done(cfg_done),
    .cfg_err (cfg_err)
  );

  initial begin
    #200us;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [NBITS-1:0] act, input logic [NBITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Expected c: the last NBITS stream bits, oldest at index 0.
  function automatic logic [NBITS-1:0] window();
    logic [NBITS-1:0] v;
    int idx;
    for (int k = 0; k < NBITS; k++) begin
      idx  = q.size() - NBITS + k;
      v[k] = (idx >= 0) ? q[idx] : 1'b0;
    end
    return v;
  endfunction

  function automatic bit pat_bit(input int pat, input int i);
    case (pat)
      0:       return (i == 0) ? 1'b1 : (i % 2 == 0);
      1:       return 1'($urandom_range(0, 1));
      default: return 1'b1;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input bit b, input bit check_out);
    cfg_en = 1'b1;
    cfg_in = b;
    step();
    q.push_back(b);
    cfg_en = 1'b0;
    if (check_out)
      chk("cfg_out", {79'd0, cfg_out}, {79'd0, (q.size() >= NBITS) ? q[q.size()-NBITS] : 1'b0});
  endtask

  task automatic shift_n(input int n, input int pat);
    for (int i = 0; i < n; i++) shift_bit(pat_bit(pat, i), 1'b0);
  endtask

  task automatic do_reset(input string name);
    rst_n = 1'b0; cfg_en = 1'b1; cfg_in = 1'b1; cfg_load = 1'b1; cfg_par = 1'b0;
    step();
    step();
    rst_n = 1'b1; cfg_en = 1'b0; cfg_load = 1'b0;
    q.delete();
    exp_c = '0;
    chk({name, "_c"}, c, '0);
    chk({name, "_out"}, {79'd0, cfg_out}, '0);
    chk({name, "_done"}, {79'd0, cfg_done}, '0);
    chk({name, "_err"}, {79'd0, cfg_err}, '0);
  endtask

  // Load pulse, optionally together with a shift; commit sees the pre-edge window.
  task automatic commit(input string name, input bit par, input bit exp_ok,
                        input bit with_shift, input bit b);
    logic [NBITS-1:0] pre;
    pre      = window();
    cfg_load = 1'b1;
    cfg_par  = par;
    cfg_en   = with_shift;
    cfg_in   = b;
    step();
    cfg_load = 1'b0;
    cfg_en   = 1'b0;
    if (with_shift) q.push_back(b);
    if (exp_ok) exp_c = pre;
    chk({name, "_c"}, c, exp_c);
    chk({name, "_done"}, {79'd0, cfg_done}, {79'd0, exp_ok});
    chk({name, "_err"}, {79'd0, cfg_err}, {79'd0, !exp_ok});
    step();
    chk({name, "_done_end"}, {79'd0, cfg_done}, '0);
  endtask

  initial begin
    tbl[0] = '{80,  0, 1'b1};
    tbl[1] = '{40,  1, 1'b0};
    tbl[2] = '{40,  1, 1'b1};
    tbl[3] = '{100, 1, 1'b1};
    tbl[4] = '{0,   1, 1'b0};
    tbl[5] = '{79,  1, 1'b0};
    tbl[6] = '{1,   1, 1'b1};
    tbl[7] = '{120, 2, 1'b1};

    rst_n = 1'b0; cfg_en = 1'b0; cfg_in = 1'b0; cfg_load = 1'b0; cfg_par = 1'b0;
    exp_c = '0;
    do_reset("reset");

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < tbl[v].nshift; i++)
        shift_bit(pat_bit(tbl[v].pat, i), (v == 3) && (i >= NBITS));
      commit($sformatf("vec%0d", v), ^window(), tbl[v].exp_ok, 1'b0, 1'b0);
      if (v == 0) chk("vec0_c0", {79'd0, c[0]}, {79'd0, 1'b1});
    end

    // Load together with the 81st shift; cnt must restart at 1.
    do_reset("reset_sim");
    shift_n(80, 1);
    commit("sim_ok", ^window(), 1'b1, 1'b1, 1'b1);
    shift_n(79, 1);
    commit("sim_cnt1", ^window(), 1'b1, 1'b0, 1'b0);
    shift_n(10, 1);
    commit("sim_rej", ^window(), 1'b0, 1'b1, 1'b0);
    shift_n(69, 1);
    commit("sim_after_rej", ^window(), 1'b1, 1'b0, 1'b0);

    // Reset with load while FULL clears c; reset mid-load discards the partial frame.
    shift_n(80, 1);
    do_reset("reset_load");
    shift_n(50, 1);
    do_reset("reset_partial");
    shift_n(30, 1);
    commit("discard", ^window(), 1'b0, 1'b0, 1'b0);

`ifdef CFG_PARITY_EN
    do_reset("reset_par");
    shift_n(80, 2);
    commit("par_bad", 1'b1, 1'b0, 1'b0, 1'b0);
    commit("par_good", 1'b0, 1'b1, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/connection_block_cfg_loader.md
# connection_block_cfg_loader

Serial configuration loader that produces the switch-control vector `c` for one data connection block in the fabric. It accepts a bit-serial configuration stream, shifts it into a shadow register and forwards overflow bits to the next loader in a daisy chain. On an explicit commit it transfers the shadow contents atomically to the active `c` vector, so a connection block never sees partially loaded switch settings.

## Interface
- `W`, 16: track width of the connection block being configured.
- `DATAIN`, 3: number of block data-input ports.
- `DATAOUT`, 2: number of block data-output ports.
- `NBITS`, `W*(DATAIN+DATAOUT)` (80): derived local parameter; length of `c`.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset is synchronous and active-low.
- `cfg_en` input 1: shift enable; one stream bit per cycle while high.
- `cfg_in` input 1: serial configuration bit.
- `cfg_out` output 1: registered chain output, equal to shadow bit 0, feeding the next loader's `cfg_in`.
- `cfg_load` input 1: commit request, single-cycle pulse.
- `cfg_par` input 1: expected parity bit, sampled with `cfg_load`; ignored when parity is compiled out.
- `c` output NBITS: active switch controls for the connection block.
- `cfg_done` output 1: one-cycle pulse after a successful commit.
- `cfg_err` output 1: sticky flag for a rejected commit.

## Operation
- Shadow register `sh[NBITS-1:0]`: when `cfg_en` is high, `sh <= {cfg_in, sh[NBITS-1:1]}`.
  - After NBITS shifts, the first bit shifted in sits at `sh[0]` and maps to `c[0]`.
  - Order within `c`: input-switch group i at bits `[i*W +: W]`, then output-switch groups starting at bit `DATAIN*W`.
- Bit counter `cnt`, range 0..NBITS: increments on each shift and saturates at NBITS.
  - Shifts beyond NBITS are normal daisy-chain traffic. Older bits leave through `cfg_out`; the loader keeps the last NBITS bits.
- State is decoded from `cnt`:
  - EMPTY when `cnt==0`.
  - PARTIAL when `0<cnt<NBITS`.
  - FULL when `cnt==NBITS`.
- Commit when `cfg_load` is high:
  - If FULL (and parity passes, when compiled in): `c <= sh`, `cfg_done` pulses, `cfg_err` clears, `cnt` clears.
  - If EMPTY or PARTIAL: `c` is unchanged, `cfg_err <= 1`, `cnt` is unchanged.
- `cfg_load` and `cfg_en` in the same cycle:
  - The commit uses `sh` as it was before the edge.
  - The shift still happens, so the chain is never stalled.
  - After a successful commit `cnt` becomes 1; after a rejected commit it increments normally.
- `cfg_err` stays high until a successful commit or reset.
- Reset (`rst_n` low at an edge):
  - `sh=0`, `c=0` (all switches open, so no contention on tracks), `cnt=0`, `cfg_out=0`, `cfg_done=0`, `cfg_err=0`.
  - Reset overrides a simultaneous `cfg_en` or `cfg_load`.
  - Reset during a partial load discards it.

## Timing
- `cfg_out` follows `cfg_in` by NBITS shift cycles, so a chain of K loaders needs K*NBITS shifts.
- `c` updates at the edge that samples `cfg_load`, with zero extra latency.
- `cfg_done` is high for exactly the cycle following that edge.
- `cfg_err` rises at the edge that samples a rejected `cfg_load`.
- `c` is glitch-free: it is written only at a commit edge and at reset.

## Configuration
- Macro `CFG_PARITY_EN`.
- Defined: a commit is accepted only if `^sh == cfg_par` (even parity over the shadow register).
  - On mismatch: treated as a rejected commit (`cfg_err=1`, `c` unchanged, `cnt` unchanged).
- Undefined: no parity check; `cfg_par` is ignored but the port remains, so the interface is identical in both builds.

## Structure
- Shared package `cb_cfg_pkg` holds:
  - the default constants W, DATAIN, DATAOUT;
  - function `cfg_nbits(w, din, dout)`;
  - the counter-state enum `cfg_state_t` {EMPTY, PARTIAL, FULL}.
- One sub-module, `cfg_shadow_shift`: the parameterised NBITS shift register with its `cfg_out` tap.
  - The counter, commit logic and flags stay in the top module.

## Test plan
- Reset: hold `rst_n=0` for 2 cycles -> `c=0`, `cfg_out=0`, `cfg_done=0`, `cfg_err=0`.
- Full load: shift 80 bits whose first bit is 1 and the rest alternate 0/1, then pulse `cfg_load` (parity correct) -> `c[0]=1`, `c` equals the shifted pattern, `cfg_done` high for one cycle, `cnt=0`.
- Partial load: shift 40 bits, pulse `cfg_load` -> `c` retains its previous value and `cfg_err=1`. Then shift 40 more bits and commit -> success, `cfg_err=0`.
- Chain pass-through: shift 100 bits -> `cfg_out` emits bits 0..19 during cycles 81..100; a commit loads bits 20..99.
- Simultaneous events: on the 81st shift cycle also assert `cfg_load` -> `c` gets the pre-edge `sh` and `cnt=1` afterwards. Separately, assert reset together with `cfg_load` -> `c=0`.
- Parity (with `CFG_PARITY_EN`): 80 ones with `cfg_par=1` -> rejected, `cfg_err=1`. The same load with `cfg_par=0` -> accepted.
